// File: rtl/line_buffer_ctrl.sv
// Write-side sequencer for the 4-line video line buffer: turns captured pixels and
// line/frame strobes into RAM writes and holds off output timing until lines are buffered.
module line_buffer_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int START_LINES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        line_doubler,
    input  logic        add_line,
    input  logic        in_vsync,
    input  logic        in_hsync,
    input  logic        in_valid,
    input  logic [23:0] in_data,
    output logic [11:0] wraddr,
    output logic [31:0] wrdata,
    output logic        wren,
    output logic        starttrigger,
    output logic [9:0]  frame_lines
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_FILL   = 2'd1;
    localparam logic [1:0]  ST_RUN    = 2'd2;
    localparam logic [10:0] H_LIMIT   = 11'(H_ACTIVE);
    localparam logic [1:0]  START_CNT = 2'(START_LINES);

    logic [1:0]  state_q, state_d;
    logic [1:0]  fill_q, fill_d;
    logic [9:0]  x_q, x_d;
    logic [1:0]  line_q, line_d;
    logic [9:0]  tally_q, tally_d;
    logic [9:0]  frame_q, frame_d;
    logic        ld_q, al_q;
    logic [11:0] wraddr_q, wraddr_d;
    logic [31:0] wrdata_q, wrdata_d;
    logic        wren_q, wren_d;
    logic        trig_q, trig_d;

    logic        mode_chg_s;
    logic [9:0]  x_eff_s;
    logic [1:0]  fill_inc_s;
    logic        accept_s;

    // Strobes act before a coincident pixel, so the pixel sees the post-strobe position.
    always_comb begin
        mode_chg_s = (line_doubler != ld_q) || (add_line != al_q);
        if (in_vsync || in_hsync) begin
            x_eff_s = 10'd0;
        end else begin
            x_eff_s = x_q;
        end
        if (in_vsync) begin
            line_d = 2'd0;
        end else if (in_hsync) begin
            line_d = line_q + 2'd1;
        end else begin
            line_d = line_q;
        end
        if (fill_q == 2'd3) begin
            fill_inc_s = 2'd3;
        end else begin
            fill_inc_s = fill_q + 2'd1;
        end
    end

    // Priming state machine; a mode change overrides any strobe in the same cycle.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (mode_chg_s) begin
            state_d = ST_IDLE;
            fill_d  = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_vsync) begin
                        state_d = ST_FILL;
                        fill_d  = 2'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (in_vsync) begin
                        fill_d = 2'd0;
                    end else if (in_hsync) begin
                        fill_d = fill_inc_s;
                        if (fill_inc_s == START_CNT) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        fill_d = fill_q;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                    fill_d  = 2'd0;
                end
            endcase
        end
    end

    // Pixel acceptance, write port and line/frame counters.
    always_comb begin
        accept_s = in_valid && !mode_chg_s && (state_d != ST_IDLE)
                   && ({1'b0, x_eff_s} < H_LIMIT);
        wren_d   = accept_s;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        x_d      = x_eff_s;
        if (accept_s) begin
            if (line_doubler) begin
                wraddr_d = {line_d, x_eff_s};
            end else begin
                wraddr_d = {2'b00, x_eff_s};
            end
            wrdata_d = {in_data, 8'h00};
            if (x_eff_s != 10'd1023) begin
                x_d = x_eff_s + 10'd1;
            end else begin
                x_d = x_eff_s;
            end
        end else begin
            x_d = x_eff_s;
        end
        trig_d  = (state_d == ST_RUN);
        frame_d = frame_q;
        tally_d = tally_q;
        if (in_vsync) begin
            frame_d = tally_q;
            tally_d = 10'd0;
        end else if (in_hsync && (tally_q != 10'd1023)) begin
            tally_d = tally_q + 10'd1;
        end else begin
            tally_d = tally_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            fill_q   <= 2'd0;
            x_q      <= 10'd0;
            line_q   <= 2'd0;
            tally_q  <= 10'd0;
            frame_q  <= 10'd0;
            ld_q     <= 1'b0;
            al_q     <= 1'b0;
            wraddr_q <= 12'd0;
            wrdata_q <= 32'd0;
            wren_q   <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            x_q      <= x_d;
            line_q   <= line_d;
            tally_q  <= tally_d;
            frame_q  <= frame_d;
            ld_q     <= line_doubler;
            al_q     <= add_line;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
            trig_q   <= trig_d;
        end
    end

    assign wraddr       = wraddr_q;
    assign wrdata       = wrdata_q;
    assign wren         = wren_q;
    assign starttrigger = trig_q;
    assign frame_lines  = frame_q;

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Write-side sequencer for the 4-line video line buffer that `ram2video` reads. It turns the captured pixel stream and line/frame strobes into RAM write address, data and enable. It holds off the output timing generator until a configurable number of lines are buffered, then asserts a level `starttrigger`. It re-arms that trigger whenever the output mode (`line_doubler`, `add_line`) changes.

## Interface
- `H_ACTIVE`, default 640: pixels per line written to RAM; pixels at x ≥ H_ACTIVE are dropped.
- `START_LINES`, default 2: complete lines that must be buffered after frame start before `starttrigger` asserts; legal range 1..3.
- `clock`  in  1  single system/pixel clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `line_doubler`  in  1  mode; 1 = 4-line ring addressing, 0 = single-line addressing.
- `add_line`  in  1  output-timing mode (525/526 lines); only watched for changes.
- `in_vsync`  in  1  single-cycle active-high frame-start strobe.
- `in_hsync`  in  1  single-cycle active-high line-start strobe.
- `in_valid`  in  1  pixel qualifier for `in_data`.
- `in_data`  in  24  pixel {R[23:16], G[15:8], B[7:0]}.
- `wraddr`  out  12  RAM write address.
- `wrdata`  out  32  {R, G, B, 8'h00}.
- `wren`  out  1  RAM write enable.
- `starttrigger`  out  1  level; high once the buffer is primed, low otherwise.
- `frame_lines`  out  10  hsync count of the last complete frame, saturating at 1023.

## Operation
- Counters:
  - `x` is 10 bits. It clears on `in_hsync` or `in_vsync` and increments on each accepted pixel, saturating at 1023.
  - `line` is 2 bits. It increments mod 4 on `in_hsync` and clears on `in_vsync`.
  - `fill_cnt` is 2 bits and saturating.
  - `line_tally` is 10 bits and saturating.
- Address: with `line_doubler`=1, `wraddr`={line, x}. With `line_doubler`=0, `wraddr`={2'b00, x}.
- A pixel is accepted when `in_valid`=1, state ≠ IDLE and x < H_ACTIVE. The accepted pixel drives `wren`=1 with the current `wraddr`/`wrdata`.
- Strobe priority, same cycle:
  - `in_vsync` overrides `in_hsync`, so line=0 and x=0.
  - A strobe takes effect before a coincident valid pixel; that pixel is written at x=0 of the new line.
- `frame_lines`: on each `in_vsync`, `frame_lines`←`line_tally` and `line_tally`←0. On each `in_hsync` without `in_vsync`, `line_tally` increments. The first `in_vsync` after reset latches 0.
- State machine:
  - IDLE: no writes, `starttrigger`=0. On `in_vsync` → FILL with `fill_cnt`=0.
  - FILL: writes enabled. Each `in_hsync` increments `fill_cnt`. A further `in_vsync` restarts FILL with `fill_cnt`=0. When `fill_cnt` reaches START_LINES → RUN.
  - RUN: writes enabled, `starttrigger`=1. `in_vsync` does not leave RUN.
- Mode change: `line_doubler` and `add_line` are registered every cycle. A mismatch between an input and its register is a change.
  - On a change, the state goes to IDLE in any state.
  - `fill_cnt` clears.
  - `wren` is forced 0 that cycle.
  - Any strobe in the change cycle is ignored for state purposes; x/line still update.
- Reset mid-operation: everything returns to reset values immediately, because reset is asynchronous.

## Timing
- Reset values: `wraddr`=0, `wrdata`=0, `wren`=0, `starttrigger`=0, `frame_lines`=0, state IDLE, all counters 0, mode registers 0.
- `wraddr`/`wrdata`/`wren` are registered, with 1-cycle latency from `in_valid`/`in_data`.
- `starttrigger` is registered. It rises 1 cycle after the `in_hsync` that brings `fill_cnt` to START_LINES. It falls 1 cycle after a mode change.
- `frame_lines` updates 1 cycle after `in_vsync`.
- Back-to-back valid pixels give a write every cycle, with no bubbles.
- A mode change followed by `in_vsync` 1 cycle later is accepted: FILL is entered.

## Test plan
- Reset then prime: `in_vsync`, two lines of 640 valid pixels each with `in_hsync`, `line_doubler`=1.
  - Writes go to addresses 0..639 then 1024..1663.
  - `starttrigger`=0 until 1 cycle after the 2nd `in_hsync`, then 1.
- Pixel overflow: 700 valid pixels in one line → exactly 640 writes, last `wraddr`=639 (line 0), no write for x ≥ 640.
- Ring wrap: 5 lines with `line_doubler`=1 → line field sequence 0,1,2,3,0; `wraddr` of the first pixel of the 5th line = 0.
- Mode change in RUN: toggle `line_doubler` → `starttrigger`=0 next cycle, `wren`=0. After the next `in_vsync` plus START_LINES lines, `starttrigger` returns to 1. Repeat with `add_line`.
- Frame count and collisions:
  - 525 `in_hsync` between two `in_vsync` → `frame_lines`=525.
  - `in_vsync` and `in_hsync` in the same cycle → line=0, x=0, `line_tally` not incremented.
- Async reset mid-line: assert `reset` during a pixel burst → `wren`, `starttrigger`, `frame_lines` read 0 before the next clock edge.
